// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES decryption definitions: inverse S-box table, byte indexing, InvShiftRows
package aes_pkg;

  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_HOLD
  } ilr_state_e;

  // Entry n sits at bits [2047-8n -: 8]; each literal row covers 16 consecutive entries.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic int idx(input int row, input int col);
    return 4 * col + row;
  endfunction

  function automatic logic [BYTE_W-1:0] inv_sbox_lookup(input logic [BYTE_W-1:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  // Row r of the state is rotated right by r columns.
  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        r[BLOCK_W-1-BYTE_W*idx(row, col) -: BYTE_W] =
          s[BLOCK_W-1-BYTE_W*idx(row, (col - row + 4) % 4) -: BYTE_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box lookup
module inv_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0] data_o
);

  assign data_o = inv_sbox_lookup(data_i);

endmodule

// File: rtl/inv_last_round.sv
// rtl/inv_last_round.sv - first AES decryption stage: AddRoundKey, InvShiftRows, then InvSubBytes
// through SBOX_LANES shared inverse S-boxes over 16/SBOX_LANES cycles.
module inv_last_round
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_Valid,
  output logic               o_Ready,
  input  logic [BLOCK_W-1:0] i_Data,
  input  logic [BLOCK_W-1:0] i_Key,
  output logic               o_Valid,
  input  logic               i_Ready,
  output logic [BLOCK_W-1:0] o_Data
);

  localparam int NBYTE = BLOCK_W / BYTE_W;
  localparam int NCYC  = NBYTE / SBOX_LANES;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  ilr_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BLOCK_W-1:0] data_q;
  logic               valid_q;

  logic [BLOCK_W-1:0] data_cap_d;
  logic [BLOCK_W-1:0] data_sub_d;
  logic [BYTE_W-1:0]  lane_in  [SBOX_LANES];
  logic [BYTE_W-1:0]  lane_out [SBOX_LANES];

  // Lane l serves byte cnt*SBOX_LANES + l in the current substitution cycle.
  always_comb begin
    for (int l = 0; l < SBOX_LANES; l++) begin
      lane_in[l] = '0;
      for (int k = l; k < NBYTE; k += SBOX_LANES) begin
        if (cnt_q == CNT_W'(k / SBOX_LANES)) begin
          lane_in[l] = data_q[BLOCK_W-1-BYTE_W*k -: BYTE_W];
        end
      end
    end
  end

  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .data_i(lane_in[l]),
      .data_o(lane_out[l])
    );
  end

  always_comb begin
    data_sub_d = data_q;
    for (int k = 0; k < NBYTE; k++) begin
      if (cnt_q == CNT_W'(k / SBOX_LANES)) begin
        data_sub_d[BLOCK_W-1-BYTE_W*k -: BYTE_W] = lane_out[k % SBOX_LANES];
      end
    end
  end

  assign data_cap_d = inv_shift_rows(i_Data ^ i_Key);

  // Ready in HOLD follows i_Ready so a new block can enter on the same edge the old one leaves.
  assign o_Ready = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & i_Ready);
  assign o_Valid = valid_q;
  assign o_Data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_Valid) begin
            data_q  <= data_cap_d;
            cnt_q   <= '0;
            state_q <= ST_SUB;
          end
        end
        ST_SUB: begin
          data_q <= data_sub_d;
          if (cnt_q == CNT_W'(NCYC - 1)) begin
            cnt_q   <= '0;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (i_Ready) begin
            valid_q <= 1'b0;
            if (i_Valid) begin
              data_q  <= data_cap_d;
              cnt_q   <= '0;
              state_q <= ST_SUB;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_last_round.sv
// tb/tb_inv_last_round.sv - table-driven and sequence checks of inv_last_round
module tb_inv_last_round;

  parameter int LANES = 4;
  localparam int NCYC  = 16 / LANES;
  localparam int LIMIT = 200;

  localparam logic [127:0] FIPS_D = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_K = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] FIPS_O = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] RAMP   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RAMP_O = 128'h52f3a3383009d79ebf366afb8140a5d5;

  typedef struct {
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] exp;
    string        name;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_Valid = 1'b0;
  logic         i_Ready = 1'b0;
  logic [127:0] i_Data = '0;
  logic [127:0] i_Key = '0;
  logic         o_Ready;
  logic         o_Valid;
  logic [127:0] o_Data;

  int           nvec = 0;
  int           nerr = 0;
  logic [7:0]   isb [256];
  vec_t         vecs [6];
  vec_t         b2b [3];
  logic [127:0] got [$];
  int           tgot [$];
  int           lat, sent, cyc, n;
  logic         acc, xfer;
  logic [127:0] rd, rk;

  inv_last_round #(.SBOX_LANES(LANES)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_Valid(i_Valid),
    .o_Ready(o_Ready),
    .i_Data (i_Data),
    .i_Key  (i_Key),
    .o_Valid(o_Valid),
    .i_Ready(i_Ready),
    .o_Data (o_Data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: no handshake within %0d cycles", nm, LIMIT);
  endtask

  // Reference inverse S-box derived from GF(2^8) inversion and the forward affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_isb();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : 8'h01;
      if (x != 0) for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_out(input logic [127:0] d, input logic [127:0] k);
    logic [127:0] t, r;
    t = d ^ k;
    r = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[127-8*(4*col+row) -: 8] = isb[t[127-8*(4*((col-row+4)%4)+row) -: 8]];
    return r;
  endfunction

  task automatic send(input logic [127:0] d, input logic [127:0] k, input string nm);
    int w;
    w = 0;
    i_Data  = d;
    i_Key   = k;
    i_Valid = 1'b1;
    #1;
    while (!o_Ready && w < LIMIT) begin
      @(posedge clk); #2;
      w++;
    end
    if (!o_Ready) tmo({nm, " accept"});
    @(posedge clk); #2;
    i_Valid = 1'b0;
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    while (!o_Valid && l < LIMIT) begin
      @(posedge clk); #2;
      l++;
    end
  endtask

  task automatic recv(input logic [127:0] exp, input string nm, input bit chk_lat, input int bp);
    int l;
    wait_valid(l);
    if (!o_Valid) begin
      tmo({nm, " valid"});
      return;
    end
    if (chk_lat) chk({nm, " latency"}, 128'(l), 128'(NCYC));
    chk({nm, " data"}, o_Data, exp);
    repeat (bp) begin @(posedge clk); #2; end
    i_Ready = 1'b1;
    @(posedge clk); #2;
    i_Ready = 1'b0;
    chk({nm, " pop"}, 128'(o_Valid), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{FIPS_D, FIPS_K, FIPS_O, "fips_c1"};
    vecs[1] = '{128'h0123456789abcdeffedcba9876543210, 128'h0123456789abcdeffedcba9876543210,
                {16{8'h52}}, "data_eq_key"};
    vecs[2] = '{{16{8'hff}}, 128'h0, {16{8'h7d}}, "all_ff"};
    vecs[3] = '{{16{8'h01}}, 128'h0, {16{8'h09}}, "all_01"};
    vecs[4] = '{RAMP, 128'h0, RAMP_O, "ramp_data"};
    vecs[5] = '{128'h0, RAMP, RAMP_O, "ramp_key"};
    build_isb();

    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset o_Valid", 128'(o_Valid), 128'(0));
    chk("reset o_Data", o_Data, 128'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("idle o_Ready", 128'(o_Ready), 128'(1));
    @(posedge clk); #2;

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, vecs[i].key, vecs[i].name);
      recv(vecs[i].exp, vecs[i].name, 1'b1, i % 3);
    end

    // Backpressure: seven stalled cycles in HOLD, then exactly one transfer.
    send(FIPS_D, FIPS_K, "bp");
    wait_valid(lat);
    chk("bp latency", 128'(lat), 128'(NCYC));
    for (int c = 0; c < 7; c++) begin
      chk("bp o_Valid", 128'(o_Valid), 128'(1));
      chk("bp o_Data", o_Data, FIPS_O);
      chk("bp o_Ready", 128'(o_Ready), 128'(0));
      @(posedge clk); #2;
    end
    i_Ready = 1'b1;
    #1;
    chk("bp release o_Ready", 128'(o_Ready), 128'(1));
    @(posedge clk); #2;
    i_Ready = 1'b0;
    chk("bp single transfer", 128'(o_Valid), 128'(0));
    repeat (3) begin @(posedge clk); #2; end
    chk("bp no repeat", 128'(o_Valid), 128'(0));

    // Back-to-back with i_Valid and i_Ready held high.
    b2b[0] = vecs[0];
    b2b[1] = vecs[4];
    b2b[2] = vecs[2];
    sent = 0;
    cyc = 0;
    i_Ready = 1'b1;
    i_Valid = 1'b1;
    i_Data = b2b[0].data;
    i_Key = b2b[0].key;
    while (got.size() < 3 && cyc < LIMIT * 4) begin
      #1;
      acc  = i_Valid & o_Ready;
      xfer = o_Valid & i_Ready;
      if (xfer) begin
        got.push_back(o_Data);
        tgot.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 3) begin
          i_Data = b2b[sent].data;
          i_Key = b2b[sent].key;
        end else begin
          i_Valid = 1'b0;
        end
      end
    end
    i_Ready = 1'b0;
    i_Valid = 1'b0;
    chk("b2b count", 128'(got.size()), 128'(3));
    for (int i = 0; i < got.size() && i < 3; i++) chk({"b2b ", b2b[i].name}, got[i], b2b[i].exp);
    for (int i = 1; i < tgot.size(); i++) chk("b2b spacing", 128'(tgot[i] - tgot[i-1]), 128'(NCYC + 1));
    @(posedge clk); #2;
    chk("b2b drained", 128'(o_Valid), 128'(0));

    // Reset while substituting (cnt=1), then a clean block.
    send(FIPS_D, FIPS_K, "rst_sub");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_sub o_Valid", 128'(o_Valid), 128'(0));
    chk("rst_sub o_Data", o_Data, 128'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    send(FIPS_D, FIPS_K, "after_rst_sub");
    recv(FIPS_O, "after_rst_sub", 1'b1, 0);

    // Reset while holding a result.
    send(RAMP, 128'h0, "rst_hold");
    wait_valid(lat);
    chk("rst_hold pre o_Valid", 128'(o_Valid), 128'(1));
    rst = 1'b1;
    #1;
    chk("rst_hold o_Valid", 128'(o_Valid), 128'(0));
    chk("rst_hold o_Data", o_Data, 128'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    send(RAMP, 128'h0, "after_rst_hold");
    recv(RAMP_O, "after_rst_hold", 1'b1, 1);

    // Inputs changing mid-block must not disturb the captured block.
    send(FIPS_D, FIPS_K, "chg");
    i_Valid = 1'b1;
    i_Data = RAMP;
    i_Key = 128'h0;
    n = 0;
    while (!o_Valid && n < LIMIT) begin
      #1;
      chk("chg sub o_Ready", 128'(o_Ready), 128'(0));
      @(posedge clk); #2;
      n++;
    end
    chk("chg latency", 128'(n), 128'(NCYC));
    chk("chg hold o_Ready", 128'(o_Ready), 128'(0));
    i_Valid = 1'b0;
    recv(FIPS_O, "chg", 1'b0, 2);

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
      rd = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      send(rd, rk, "rand");
      recv(ref_out(rd, rk), "rand", 1'b1, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
